// File: rtl/poly_pkg.sv
// poly_pkg: shared FSM states, ALU opcodes, operand selects and packed-operand field indices.
package poly_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CYC0, S_CYC1, S_CYC2, S_CYC3, S_RESP} state_t;
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;
    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;
    // field index within the packed operand bus, scaled by W at the use site
    localparam int F_A = 3;
    localparam int F_B = 2;
    localparam int F_C = 1;
    localparam int F_X = 0;
endpackage

// File: rtl/poly_alu_core.sv
// poly_alu_core: A/B/C/X operand registers, two 4:1 selects, add/mul ALU and result register.
module poly_alu_core
    import poly_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           ld,
    input  logic [4*W-1:0] opnd,
    input  logic [1:0]     sel_l,
    input  logic [1:0]     sel_r,
    input  logic           op,
    input  logic           wr_a,
    input  logic           wr_b,
    input  logic           wr_r,
    output logic [W-1:0]   res
);
    logic [W-1:0] a, b, c, x, lo, ro, y;
    always_comb begin
        lo = sel_l == SEL_A ? a : sel_l == SEL_B ? b : sel_l == SEL_C ? c : x;
        ro = sel_r == SEL_A ? a : sel_r == SEL_B ? b : sel_r == SEL_C ? c : x;
        y  = op == ALU_MUL ? lo * ro : lo + ro;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a   <= '0;
            b   <= '0;
            c   <= '0;
            x   <= '0;
            res <= '0;
        end else begin
            a   <= ld ? opnd[F_A*W +: W] : wr_a ? y : a;
            b   <= ld ? opnd[F_B*W +: W] : wr_b ? y : b;
            c   <= ld ? opnd[F_C*W +: W] : c;
            x   <= ld ? opnd[F_X*W +: W] : x;
            res <= wr_r ? y : res;
        end
    end
endmodule

// File: rtl/poly_arbiter.sv
// poly_arbiter: round-robin two-requester front end sequencing R = (A + B*X)*X + C mod 2^W.
module poly_arbiter
    import poly_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [1:0]     req_valid,
    input  logic [4*W-1:0] req0_opnd,
    input  logic [4*W-1:0] req1_opnd,
    output logic [1:0]     req_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [W-1:0]   resp_data,
    output logic           busy,
    output logic [7:0]     jobs_done
);
    state_t state, nxt;
    logic last, tag, g, acc, ld, op, wr_a, wr_b, wr_r;
    logic [1:0] sel_l, sel_r;
    // on a tie the requester that did not win last time is granted
    assign g          = &req_valid ? ~last : req_valid[1];
    assign req_ready  = (state == S_IDLE && resetn && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign acc        = |(req_valid & req_ready);
    assign resp_valid = state == S_RESP;
    assign busy       = state != S_IDLE;
    always_comb begin
        nxt   = state;
        ld    = 1'b0;
        sel_l = SEL_A;
        sel_r = SEL_B;
        op    = ALU_ADD;
        wr_a  = 1'b0;
        wr_b  = 1'b0;
        wr_r  = 1'b0;
        case (state)
            S_IDLE: begin
                ld  = acc;
                nxt = acc ? S_CYC0 : S_IDLE;
            end
            S_CYC0: begin
                sel_l = SEL_B;
                sel_r = SEL_X;
                op    = ALU_MUL;
                wr_b  = 1'b1;
                nxt   = S_CYC1;
            end
            S_CYC1: begin
                wr_a = 1'b1;
                nxt  = S_CYC2;
            end
            S_CYC2: begin
                sel_r = SEL_X;
                op    = ALU_MUL;
                wr_a  = 1'b1;
                nxt   = S_CYC3;
            end
            S_CYC3: begin
                sel_r = SEL_C;
                wr_r  = 1'b1;
                nxt   = S_RESP;
            end
            S_RESP:  nxt = resp_ready ? S_IDLE : S_RESP;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            tag       <= 1'b0;
            resp_id   <= 1'b0;
            jobs_done <= 8'h00;
        end else begin
            state <= nxt;
            if (acc) begin
                last <= g;
                tag  <= g;
            end
            if (state == S_CYC3) resp_id <= tag;
            if (resp_valid && resp_ready) jobs_done <= jobs_done + 8'd1;
        end
    end
    poly_alu_core #(.W(W)) u_core (
        .clk    (clk),
        .resetn (resetn),
        .ld     (ld),
        .opnd   (g ? req1_opnd : req0_opnd),
        .sel_l  (sel_l),
        .sel_r  (sel_r),
        .op     (op),
        .wr_a   (wr_a),
        .wr_b   (wr_b),
        .wr_r   (wr_r),
        .res    (resp_data)
    );
endmodule

// File: doc/poly_arbiter.md
# poly_arbiter

Two-requester front end for the polynomial engine. It accepts jobs of four 8-bit operands (A, B, C, X) over valid/ready handshakes and grants the engine round-robin. It sequences a private register/ALU core through the fixed four-step evaluation R = (A + B·X)·X + C, with each step truncated mod 256. It returns the tagged result over a valid/ready response channel. It sits between board-level input logic or a bus adapter and the display/result consumers.

## Interface
- `W`, default 8: operand/result width; only 8 is verified.
- `clk`  in  1  system clock, all logic rising-edge.
- `resetn`  in  1  synchronous, active-low reset.
- `req_valid`  in  2  per-requester job valid; bit i = requester i.
- `req0_opnd`  in  4W  requester 0 operands, packed {A[31:24], B[23:16], C[15:8], X[7:0]}.
- `req1_opnd`  in  4W  requester 1 operands, same packing.
- `req_ready`  out  2  per-requester accept; at most one bit set.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  1  requester index that owns `resp_data`.
- `resp_data`  out  W  result R.
- `busy`  out  1  high in any state other than IDLE.
- `jobs_done`  out  8  count of completed response handshakes, wraps 0xFF→0x00.

## Operation
- FSM states: IDLE, CYC0, CYC1, CYC2, CYC3, RESP.
- IDLE: compute grant combinationally from `req_valid` and the `last` pointer. `req_ready[g] = 1` for the granted requester only. The grant never depends on `resp_ready`.
- Round-robin: if only one requester is valid, it wins. If both are valid, the requester other than `last` wins. After reset `last` = 1, so requester 0 wins the first tie.
- Handshake (`req_valid[g] & req_ready[g]`): load A, B, C, X from the granted operand bus, store `g` as the tag, set `last <= g`, and go to CYC0.
- CYC0: B ← B·X.
- CYC1: A ← A + B.
- CYC2: A ← A·X.
- CYC3: result register ← A + C. Go to RESP.
- Every ALU result is the low W bits of the full result; no saturation, no carry-out.
- RESP: `resp_valid = 1`, with `resp_id` and `resp_data` stable. On `resp_ready`: increment `jobs_done` and go to IDLE. Otherwise stay in RESP.
- Outside IDLE, `req_ready = 2'b00`. Requesters must hold `req_valid` and operands until accepted. A requester that drops `req_valid` before acceptance is simply not served.
- Reset mid-operation: the in-flight job is discarded and the FSM returns to IDLE. All registers, operands, tag, result, `jobs_done` and `last` (= 1) return to their reset values. No response is produced for the discarded job.

## Timing
- Reset values: `req_ready` = 0 while `resetn` is low. `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0x00, `busy` = 0, `jobs_done` = 0x00.
- Accept at edge T puts the FSM in CYC0 during cycle T+1. CYC3 runs in cycle T+4.
- `resp_valid` is first high in cycle T+5 (latency 5 cycles).
- With `resp_ready` held high, the response handshake happens in T+5 and IDLE is reached in T+6. The earliest next accept is cycle T+6, giving a throughput of 1 job / 6 cycles.
- A `req_valid` that arrives in the same cycle as the response handshake is not accepted until IDLE.
- `resp_*` outputs are registered and change only on RESP entry or reset.

## Structure
- Shared package `poly_pkg` holds:
  - FSM state encodings.
  - ALU opcodes ALU_ADD=0, ALU_MUL=1.
  - Operand select codes SEL_A=0, SEL_B=1, SEL_C=2, SEL_X=3.
  - Packed-operand field offsets.
- Sub-module `poly_alu_core` holds the A/B/C/X registers, two 4:1 select muxes, the add/mul ALU and the result register. It is driven by ld_*/select/op strobes from the FSM.
- The arbiter, FSM and `jobs_done` counter live in `poly_arbiter`.

## Test plan
- Basic job: reset, then req0 A=1 B=2 C=3 X=4 with `resp_ready` = 1. Required response: `resp_valid` exactly 5 cycles after accept, `resp_data` = 0x27, `resp_id` = 0, `jobs_done` = 1.
- Truncation: req1 A=0x10 B=0x10 C=0x05 X=0x10. B·X wraps to 0x00, giving `resp_data` = 0x05 and `resp_id` = 1.
- Fairness: both `req_valid` held high for 4 jobs with distinct operands. Grants must go 0,1,0,1. `req_ready` must be one-hot in IDLE and zero elsewhere.
- Backpressure: hold `resp_ready` = 0 for 10 cycles in RESP. `resp_valid`, `resp_data` and `resp_id` must stay stable, `req_ready` = 00 throughout, and no second job is accepted. Release `resp_ready`: IDLE follows on the next cycle.
- Reset mid-job: assert `resetn` = 0 during CYC2. The next cycle shows all outputs at reset values and no response for the discarded job. Then apply both requests valid: requester 0 wins.
- Counter wrap: complete 256 jobs. `jobs_done` must read 0xFF after 255 and 0x00 after the 256th.
